mul_result_reader: RTL and testbench

//  Read-side partner of the multiplier master: drains the 16-word result RAM the master fills
//  (even addr = low word v, odd addr = high word u). After the master finishes, it reads word

---
 rtl/mul_result_reader_pkg.sv | 22 ++
 rtl/mul_result_reader_if.sv | 28 ++
 rtl/mul_result_reader.sv | 160 ++++++++++++++++
 tb/tb_mul_result_reader.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_result_reader_pkg.sv
// Shared definitions for the multiplier result reader: FSM encoding, default widths and
// the result-RAM word layout (even address = low word, odd address = high word).
package mul_result_reader_pkg;

    localparam int AW_DEF         = 4;
    localparam int DW_DEF         = 32;

    // Result RAM pair layout, shared with the writer side.
    localparam int LO_WORD_OFS    = 0;
    localparam int HI_WORD_OFS    = 1;
    localparam int WORDS_PER_PAIR = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_LO   = 3'd1,
        ST_RD_HI   = 3'd2,
        ST_CAP     = 3'd3,
        ST_PRESENT = 3'd4,
        ST_DONE    = 3'd5
    } rdr_state_e;

endpackage

// File: rtl/mul_result_reader_if.sv
// Result RAM read port plus product stream of the result reader.
// master = the reader itself, slave = RAM/consumer side.
interface mul_result_reader_if
    import mul_result_reader_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
);

    logic              rd_en;
    logic [AW-1:0]     raddr;
    logic [DW-1:0]     rd_data;
    logic [2*DW-1:0]   product;
    logic [AW-2:0]     prod_index;
    logic              prod_valid;
    logic              prod_ready;

    modport master (
        output rd_en, raddr, product, prod_index, prod_valid,
        input  rd_data, prod_ready
    );

    modport slave (
        input  rd_en, raddr, product, prod_index, prod_valid,
        output rd_data, prod_ready
    );

endinterface

// File: rtl/mul_result_reader.sv
// Drains the result RAM word pairs after the master finishes, assembling 64-bit products
// {high, low} and presenting them one at a time over a valid/ready handshake.
module mul_result_reader
    import mul_result_reader_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
)
(
    input  logic                clk,
    input  logic                reset,
    input  logic                start_i,
    input  logic                clear_i,
    input  logic [AW:0]         wr_count_i,
    mul_result_reader_if.master bus,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_odd_o
);

    localparam int unsigned DEPTH    = 2**AW;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] PAIR_CNT = (AW+1)'(WORDS_PER_PAIR);

    rdr_state_e       state_q;
    logic [AW:0]      ptr_q;
    logic [AW:0]      cnt_q;
    logic             rd_en_q;
    logic [AW-1:0]    raddr_q;
    logic [2*DW-1:0]  product_q;
    logic [AW-2:0]    prod_index_q;
    logic             prod_valid_q;
    logic             busy_q;
    logic             done_q;
    logic             err_odd_q;

    logic [AW:0]      start_cnt_d;
    logic [AW:0]      ptr_d;
    logic             last_pair_d;
    logic             handshake_d;

    // Counts beyond the RAM depth cannot name real words, so they saturate at a full RAM.
    function automatic logic [AW:0] clamp_count(input logic [AW:0] wc);
        return (wc > FULL_CNT) ? FULL_CNT : wc;
    endfunction

    function automatic logic [AW-1:0] word_addr(input logic [AW:0] ptr, input int ofs);
        return ptr[AW-1:0] + AW'(ofs);
    endfunction

    always_comb begin
        start_cnt_d = clamp_count(wr_count_i);
        ptr_d       = ptr_q + PAIR_CNT;
        // Extra bit keeps ptr+2 from wrapping when the pointer reaches a full RAM.
        last_pair_d = ({1'b0, ptr_d} + (AW+2)'(WORDS_PER_PAIR)) > {1'b0, cnt_q};
        handshake_d = prod_valid_q & bus.prod_ready;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            cnt_q        <= '0;
            rd_en_q      <= 1'b0;
            raddr_q      <= '0;
            product_q    <= '0;
            prod_index_q <= '0;
            prod_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_odd_q    <= 1'b0;
        end else if (clear_i && (state_q != ST_IDLE)) begin
            // Abort wins over any same-cycle handshake: the presented product is dropped.
            state_q      <= ST_IDLE;
            rd_en_q      <= 1'b0;
            prod_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_odd_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i && !clear_i) begin
                        cnt_q     <= start_cnt_d;
                        ptr_q     <= '0;
                        err_odd_q <= wr_count_i[0];
                        if (start_cnt_d < PAIR_CNT) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_RD_LO;
                            rd_en_q <= 1'b1;
                            raddr_q <= word_addr('0, LO_WORD_OFS);
                            busy_q  <= 1'b1;
                        end
                    end
                end

                ST_RD_LO: begin
                    state_q <= ST_RD_HI;
                    rd_en_q <= 1'b1;
                    raddr_q <= word_addr(ptr_q, HI_WORD_OFS);
                end

                // RAM data lags the address by one cycle: low word arrives here.
                ST_RD_HI: begin
                    state_q           <= ST_CAP;
                    rd_en_q           <= 1'b0;
                    product_q[DW-1:0] <= bus.rd_data;
                end

                ST_CAP: begin
                    state_q              <= ST_PRESENT;
                    product_q[2*DW-1:DW] <= bus.rd_data;
                    prod_index_q         <= ptr_q[AW-1:1];
                    prod_valid_q         <= 1'b1;
                end

                ST_PRESENT: begin
                    if (handshake_d) begin
                        prod_valid_q <= 1'b0;
                        ptr_q        <= ptr_d;
                        if (last_pair_d) begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_RD_LO;
                            rd_en_q <= 1'b1;
                            raddr_q <= word_addr(ptr_d, LO_WORD_OFS);
                        end
                    end
                end

                ST_DONE: begin
                    state_q <= ST_DONE;
                end

                default: begin
                    state_q      <= ST_IDLE;
                    rd_en_q      <= 1'b0;
                    prod_valid_q <= 1'b0;
                    busy_q       <= 1'b0;
                    done_q       <= 1'b0;
                    err_odd_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rd_en      = rd_en_q;
    assign bus.raddr      = raddr_q;
    assign bus.product    = product_q;
    assign bus.prod_index = prod_index_q;
    assign bus.prod_valid = prod_valid_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign err_odd_o      = err_odd_q;

endmodule

// File: tb/tb_mul_result_reader.sv
// Randomized bench for mul_result_reader: a RAM model plus a queue of expected products
// derived from RAM contents and the word count, checked every cycle a product is offered.
module tb_mul_result_reader;

    localparam int AW = 4;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          clear;
    logic [AW:0]   wr_count;
    logic          busy;
    logic          done;
    logic          err_odd;

    mul_result_reader_if #(.AW(AW), .DW(DW)) bus ();

    mul_result_reader #(.AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start_i    (start),
        .clear_i    (clear),
        .wr_count_i (wr_count),
        .bus        (bus),
        .busy_o     (busy),
        .done_o     (done),
        .err_odd_o  (err_odd)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [16];

    always @(posedge clk) begin
        if (bus.rd_en) bus.rd_data <= mem[bus.raddr];
    end

    logic [2*DW-1:0] exp_q [$];
    int              exp_idx_q [$];
    logic [2*DW-1:0] seen_prod [8];
    bit              chk_en;
    int              rd_cycles;
    int              checks;
    int              errors;

    function automatic void check(input string name, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, expv);
        end
    endfunction

    // Compare process: every offered product must be the head of the expected queue.
    always @(negedge clk) begin
        if (chk_en) begin
            if (bus.rd_en) rd_cycles++;
            if (bus.prod_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_product", 64'(bus.prod_valid), 64'd0);
                end else begin
                    check("product", bus.product, exp_q[0]);
                    check("prod_index", 64'(bus.prod_index), 64'(exp_idx_q[0]));
                    check("busy_while_valid", 64'(busy), 64'd1);
                    check("rd_en_while_valid", 64'(bus.rd_en), 64'd0);
                    seen_prod[bus.prod_index] = bus.product;
                    if (bus.prod_ready && !clear && !reset) begin
                        void'(exp_q.pop_front());
                        void'(exp_idx_q.pop_front());
                    end
                end
            end
            if (done) begin
                check("busy_when_done", 64'(busy), 64'd0);
                check("rd_en_when_done", 64'(bus.rd_en), 64'd0);
            end
        end
    end

    task automatic load_expect(input int wc);
        int n;
        n = ((wc > 16) ? 16 : wc) / 2;
        exp_q.delete();
        exp_idx_q.delete();
        for (int k = 0; k < n; k++) begin
            exp_q.push_back({mem[2*k+1], mem[2*k]});
            exp_idx_q.push_back(k);
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
    endtask

    // mode 0: ready always high, 1: random ready, 2: first product stalled 5 cycles.
    task automatic run_txn(input int wc, input int mode);
        int  n;
        int  j;
        int  stall;
        int  first_valid;
        int  done_at;
        n = ((wc > 16) ? 16 : wc) / 2;
        load_expect(wc);
        for (int i = 0; i < 8; i++) seen_prod[i] = '0;
        rd_cycles   = 0;
        chk_en      = 1'b1;
        stall       = 0;
        first_valid = -1;
        done_at     = -1;
        j           = 0;
        wr_count    = wc[AW:0];
        start       = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        wr_count = 5'($urandom_range(0, 31));
        while (done_at < 0) begin
            if (done) begin
                done_at = j;
            end else begin
                if (bus.prod_valid && first_valid < 0) first_valid = j;
                case (mode)
                    0:       bus.prod_ready = 1'b1;
                    1:       bus.prod_ready = 1'($urandom_range(0, 1));
                    default: begin
                        if (bus.prod_valid && stall < 5) begin
                            bus.prod_ready = 1'b0;
                            stall++;
                        end else begin
                            bus.prod_ready = 1'b1;
                        end
                    end
                endcase
                @(posedge clk); #1;
                j++;
                if (j > 300) begin
                    check("done_timeout", 64'(done), 64'd1);
                    done_at = j;
                end
            end
        end
        check("pairs_left", 64'(exp_q.size()), 64'd0);
        check("err_odd", 64'(err_odd), 64'(wc % 2));
        check("rd_cycles", 64'(rd_cycles), 64'(2 * n));
        if (mode == 0) begin
            check("done_latency", 64'(done_at), 64'(4 * n));
            if (n > 0) check("first_valid_latency", 64'(first_valid), 64'd3);
        end
        // start must be ignored once DONE; outputs hold until clear.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("done_held", 64'(done), 64'd1);
        check("err_odd_held", 64'(err_odd), 64'(wc % 2));
        check("no_read_in_done", 64'(bus.rd_en), 64'd0);
        clear = 1'b1;
        @(posedge clk); #1;
        clear  = 1'b0;
        chk_en = 1'b0;
        check("clear_done", 64'(done), 64'd0);
        check("clear_err_odd", 64'(err_odd), 64'd0);
        check("clear_busy", 64'(busy), 64'd0);
        bus.prod_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_en"}, 64'(bus.rd_en), 64'd0);
        check({tag, "_raddr"}, 64'(bus.raddr), 64'd0);
        check({tag, "_product"}, bus.product, 64'd0);
        check({tag, "_prod_index"}, 64'(bus.prod_index), 64'd0);
        check({tag, "_prod_valid"}, 64'(bus.prod_valid), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_err_odd"}, 64'(err_odd), 64'd0);
    endtask

    initial begin
        longint v;
        int     guard;
        checks         = 0;
        errors         = 0;
        chk_en         = 1'b0;
        reset          = 1'b1;
        start          = 1'b0;
        clear          = 1'b0;
        wr_count       = '0;
        bus.prod_ready = 1'b0;
        fill_random();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_reset_outputs("reset");

        // Single pair, literal product.
        fill_random();
        mem[0] = 32'h0000_0006;
        mem[1] = 32'h0000_0000;
        run_txn(2, 0);
        check("t1_product_literal", seen_prod[0], 64'h0000_0000_0000_0006);

        // Full RAM of signed products (-3)*k.
        for (int k = 0; k < 8; k++) begin
            v = -3 * longint'(k);
            mem[2*k]   = v[31:0];
            mem[2*k+1] = v[63:32];
        end
        run_txn(16, 0);
        check("t2_index1_literal", seen_prod[1], 64'hFFFF_FFFF_FFFF_FFFD);
        check("t2_index7_literal", seen_prod[7], 64'hFFFF_FFFF_FFFF_FFEB);

        // Stalled consumer, odd count, too-short counts, clamped count.
        fill_random();
        run_txn(4, 2);
        fill_random();
        run_txn(5, 0);
        run_txn(0, 0);
        run_txn(1, 0);
        fill_random();
        run_txn(20, 1);

        // Clear while the second pair is in CAP: only the first product counts as delivered.
        fill_random();
        load_expect(16);
        chk_en         = 1'b1;
        bus.prod_ready = 1'b1;
        wr_count       = 5'd16;
        start          = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear  = 1'b0;
        chk_en = 1'b0;
        check("t5_delivered_before_clear", 64'(exp_q.size()), 64'd7);
        check("t5_prod_valid", 64'(bus.prod_valid), 64'd0);
        check("t5_done", 64'(done), 64'd0);
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_rd_en", 64'(bus.rd_en), 64'd0);

        // start together with clear in IDLE does nothing.
        wr_count = 5'd4;
        start    = 1'b1;
        clear    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        clear = 1'b0;
        check("t5_sc_busy", 64'(busy), 64'd0);
        check("t5_sc_rd_en", 64'(bus.rd_en), 64'd0);
        @(posedge clk); #1;
        check("t5_sc_busy2", 64'(busy), 64'd0);
        check("t5_sc_done2", 64'(done), 64'd0);
        check("t5_sc_rd_en2", 64'(bus.rd_en), 64'd0);
        bus.prod_ready = 1'b0;

        // Reset while a product is being presented.
        fill_random();
        wr_count = 5'd5;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        guard = 0;
        while (!bus.prod_valid && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check("t6_reached_present", 64'(bus.prod_valid), 64'd1);
        check("t6_err_odd_before_reset", 64'(err_odd), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_reset_outputs("t6");
        fill_random();
        run_txn(6, 1);

        // Random mix of counts and consumer behaviour.
        for (int t = 0; t < 12; t++) begin
            fill_random();
            run_txn(int'($urandom_range(0, 20)), int'($urandom_range(0, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
